// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), coordinate width,
// play-field limits used by the renderers, and a small window-decode helper.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam int CLK_DIV_DEFAULT  = 4;
    localparam logic SYNC_POL_DEFAULT = 1'b0;

    // Play-field limits shared by the ball, paddle and brick renderers.
    localparam int WALL_THICK   = 8;
    localparam int FIELD_LEFT   = WALL_THICK;
    localparam int FIELD_RIGHT  = H_ACTIVE - WALL_THICK - 1;
    localparam int FIELD_TOP    = WALL_THICK;
    localparam int FIELD_BOTTOM = V_ACTIVE - 1;

    // True when start <= pos < start + width.
    function automatic logic in_window(input logic [COORD_W-1:0] pos,
                                       input int start,
                                       input int width);
        int p;
        p = int'(pos);
        return (p >= start) && (p < start + width);
    endfunction

endpackage

// File: rtl/vga_sync_gen_pixel_tick_div.sv
// Clock divider producing a one-clock strobe every CLK_DIV system clocks.
// With CLK_DIV = 1 the counter stays at zero and the strobe is always high.
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    output logic pixel_tick_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;

    assign pixel_tick_o = (div_cnt_q == DIV_LAST);

    // Wrap to zero on the terminal count, otherwise count up.
    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        if (pixel_tick_o) begin
            div_cnt_d = '0;
        end
    end

    // Divider count register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA scan timing: pixel-rate divider, horizontal/vertical scan counters,
// sync decode, video-active qualifier and a once-per-frame tick issued on
// the first clock of the first blanking line.
module vga_sync_gen #(
    parameter int   CLK_DIV  = vga_timing_pkg::CLK_DIV_DEFAULT,
    parameter int   H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int   H_FRONT  = vga_timing_pkg::H_FRONT,
    parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int   H_BACK   = vga_timing_pkg::H_BACK,
    parameter int   V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int   V_FRONT  = vga_timing_pkg::V_FRONT,
    parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int   V_BACK   = vga_timing_pkg::V_BACK,
    parameter logic SYNC_POL = vga_timing_pkg::SYNC_POL_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    output logic       pixel_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_tick
);

    import vga_timing_pkg::*;

    localparam int H_TOT    = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT    = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_ACTIVE + H_FRONT;
    localparam int VS_START = V_ACTIVE + V_FRONT;

    localparam logic [COORD_W-1:0] H_LAST  = COORD_W'(H_TOT - 1);
    localparam logic [COORD_W-1:0] V_LAST  = COORD_W'(V_TOT - 1);
    localparam logic [COORD_W-1:0] H_VIS   = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_VIS   = COORD_W'(V_ACTIVE);

    if (H_TOT > (1 << COORD_W)) begin : g_bad_h_total
        $error("vga_sync_gen: horizontal total exceeds coordinate range");
    end
    if (V_TOT > (1 << COORD_W)) begin : g_bad_v_total
        $error("vga_sync_gen: vertical total exceeds coordinate range");
    end
    if ((CLK_DIV < 1) || (CLK_DIV > 16)) begin : g_bad_clk_div
        $error("vga_sync_gen: CLK_DIV outside 1..16");
    end

    logic               pixel_tick_w;
    logic [COORD_W-1:0] h_q, h_d;
    logic [COORD_W-1:0] v_q, v_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               frame_tick_q, frame_tick_d;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_div (
        .clock        (clock),
        .reset        (reset),
        .pixel_tick_o (pixel_tick_w)
    );

    // Next scan position; syncs and frame tick are decoded from it so the
    // registered outputs line up with the registered counts.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (pixel_tick_w) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d = '0;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end else begin
                h_d = h_q + 1'b1;
            end
        end
        hsync_d = in_window(h_d, HS_START, H_SYNC) ? SYNC_POL : ~SYNC_POL;
        vsync_d = in_window(v_d, VS_START, V_SYNC) ? SYNC_POL : ~SYNC_POL;
        // Only the edge that moves the counts onto (0, V_ACTIVE) fires the
        // tick, so it stays single-cycle while that position is held.
        frame_tick_d = pixel_tick_w && (h_d == '0) && (v_d == V_VIS);
    end

    // Scan counters and registered timing outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_q          <= '0;
            v_q          <= '0;
            hsync_q      <= ~SYNC_POL;
            vsync_q      <= ~SYNC_POL;
            frame_tick_q <= 1'b0;
        end else begin
            h_q          <= h_d;
            v_q          <= v_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign pixel_tick = pixel_tick_w;
    assign pixel_x    = h_q;
    assign pixel_y    = v_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign frame_tick = frame_tick_q;
    assign video_on   = (h_q < H_VIS) && (v_q < V_VIS);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen using a shrunken raster (15x10 totals) so whole
// frames fit in a short run; one instance divides by 4, one by 1.
module tb_vga_sync_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 6, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       pt;
        logic       hs;
        logic       vs;
        logic       von;
        logic       ft;
    } obs_t;

    typedef struct {
        int   k;
        obs_t e;
    } vec_t;

    logic       clock;
    logic       reset;
    logic       pt4, hs4, vs4, von4, ft4;
    logic [9:0] px4, py4;
    logic       pt1, hs1, vs1, von1, ft1;
    logic [9:0] px1, py1;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   k       = 0;
    obs_t q4[$];
    obs_t q1[$];

    vga_sync_gen #(
        .CLK_DIV(4), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1'b0)
    ) u_dut4 (
        .clock(clock), .reset(reset), .pixel_tick(pt4), .pixel_x(px4),
        .pixel_y(py4), .hsync(hs4), .vsync(vs4), .video_on(von4),
        .frame_tick(ft4)
    );

    vga_sync_gen #(
        .CLK_DIV(1), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1'b0)
    ) u_dut1 (
        .clock(clock), .reset(reset), .pixel_tick(pt1), .pixel_x(px1),
        .pixel_y(py1), .hsync(hs1), .vsync(vs1), .video_on(von1),
        .frame_tick(ft1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Expected outputs after k edges since reset release, from absolute time.
    function automatic obs_t model(input int kk, input int div);
        obs_t e;
        int p, x, y;
        p = kk / div;
        x = p % HT;
        y = (p / HT) % VT;
        e.x   = 10'(x);
        e.y   = 10'(y);
        e.pt  = ((kk % div) == div - 1);
        e.hs  = !((x >= HA + HF) && (x < HA + HF + HS));
        e.vs  = !((y >= VA + VF) && (y < VA + VF + VS));
        e.von = (x < HA) && (y < VA);
        e.ft  = ((kk % div) == 0) && (x == 0) && (y == VA);
        return e;
    endfunction

    function automatic vec_t mk(input int kk, input int x, input int y,
                                input logic pt, input logic hs, input logic vs,
                                input logic von, input logic ft);
        vec_t v;
        v.k     = kk;
        v.e.x   = 10'(x);
        v.e.y   = 10'(y);
        v.e.pt  = pt;
        v.e.hs  = hs;
        v.e.vs  = vs;
        v.e.von = von;
        v.e.ft  = ft;
        return v;
    endfunction

    function automatic obs_t sample4();
        obs_t a;
        a.x = px4; a.y = py4; a.pt = pt4; a.hs = hs4;
        a.vs = vs4; a.von = von4; a.ft = ft4;
        return a;
    endfunction

    function automatic obs_t sample1();
        obs_t a;
        a.x = px1; a.y = py1; a.pt = pt1; a.hs = hs1;
        a.vs = vs1; a.von = von1; a.ft = ft1;
        return a;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_obs(input string name, input obs_t act, input obs_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s k=%0d: got x=%0d y=%0d pt=%b hs=%b vs=%b von=%b ft=%b expected x=%0d y=%0d pt=%b hs=%b vs=%b von=%b ft=%b",
                     name, k, act.x, act.y, act.pt, act.hs, act.vs, act.von, act.ft,
                     exp.x, exp.y, exp.pt, exp.hs, exp.vs, exp.von, exp.ft);
        end
    endtask

    // Push the expected state for each edge as it is applied.
    always @(posedge clock) begin
        if (reset) k = 0;
        else       k = k + 1;
        q4.push_back(model(k, 4));
        q1.push_back(model(k, 1));
    end

    // Pop and compare against the DUT away from the active edge.
    always @(negedge clock) begin
        if (q4.size() > 0) chk_obs("sb_div4", sample4(), q4.pop_front());
        if (q1.size() > 0) chk_obs("sb_div1", sample1(), q1.pop_front());
    end

    initial begin
        vec_t tbl[$];
        int   vs4_fall[$], vs1_fall[$], ft4_rise[$], ft1_rise[$];
        int   ft4_wide, ft1_wide, hs_start_x, hs_len, vs_len, run;
        logic p_vs4, p_vs1, p_ft4, p_ft1, p_hs4, hs_done, vs_done, found;

        reset = 1'b1;

        //            k    x   y  pt hs vs von ft
        tbl.push_back(mk(0,   0,  0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(2,   0,  0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(3,   0,  0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(4,   1,  0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(32,  8,  0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(40, 10,  0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(51, 12,  0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(52, 13,  0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(60,  0,  1, 0, 1, 1, 1, 0));
        tbl.push_back(mk(360, 0,  6, 0, 1, 1, 0, 1));
        tbl.push_back(mk(361, 0,  6, 0, 1, 1, 0, 0));
        tbl.push_back(mk(420, 0,  7, 0, 1, 0, 0, 0));
        tbl.push_back(mk(540, 0,  9, 0, 1, 1, 0, 0));
        tbl.push_back(mk(599, 14, 9, 1, 1, 1, 0, 0));
        tbl.push_back(mk(600, 0,  0, 0, 1, 1, 1, 0));

        // Hold reset for three clocks, checking the held values each time.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            chk_obs("reset_hold", sample4(), mk(0, 0, 0, 0, 1, 1, 1, 0).e);
            chk("reset_hold_pt1", int'(pt1), 1);
        end
        #1 reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            while (k < tbl[i].k) @(negedge clock);
            #1;
            chk_obs("vec", sample4(), tbl[i].e);
        end

        // Free-run: line/frame timing measured from edges of the outputs.
        ft4_wide = 0; ft1_wide = 0; hs_start_x = -1; hs_len = 0; vs_len = 0;
        hs_done = 1'b0; vs_done = 1'b0;
        p_vs4 = vs4; p_vs1 = vs1; p_ft4 = ft4; p_ft1 = ft1; p_hs4 = hs4;
        for (int c = 0; c < 1400; c++) begin
            @(negedge clock);
            #1;
            if (p_vs4 && !vs4) vs4_fall.push_back(c);
            if (p_vs1 && !vs1) vs1_fall.push_back(c);
            if (ft4) begin
                if (p_ft4) ft4_wide++; else ft4_rise.push_back(c);
            end
            if (ft1) begin
                if (p_ft1) ft1_wide++; else ft1_rise.push_back(c);
            end
            if (!hs_done) begin
                if (p_hs4 && !hs4) begin hs_start_x = int'(px4); hs_len = 1; end
                else if (!hs4 && hs_len > 0) hs_len++;
                else if (hs4 && hs_len > 0) hs_done = 1'b1;
            end
            if (!vs_done && vs4_fall.size() > 0) begin
                if (!vs4) vs_len++;
                else vs_done = 1'b1;
            end
            p_vs4 = vs4; p_vs1 = vs1; p_ft4 = ft4; p_ft1 = ft1; p_hs4 = hs4;
        end
        chk("hsync_start_x", hs_start_x, HA + HF);
        chk("hsync_low_clocks", hs_len, HS * 4);
        chk("vsync_low_clocks", vs_len, VS * HT * 4);
        chk("vsync_period_div4",
            (vs4_fall.size() >= 2) ? vs4_fall[1] - vs4_fall[0] : -1, HT * VT * 4);
        chk("frame_tick_spacing_div4",
            (ft4_rise.size() >= 2) ? ft4_rise[1] - ft4_rise[0] : -1, HT * VT * 4);
        chk("frame_tick_width_div4", ft4_wide, 0);
        chk("vsync_period_div1",
            (vs1_fall.size() >= 2) ? vs1_fall[1] - vs1_fall[0] : -1, HT * VT);
        chk("frame_tick_spacing_div1",
            (ft1_rise.size() >= 2) ? ft1_rise[1] - ft1_rise[0] : -1, HT * VT);
        chk("frame_tick_width_div1", ft1_wide, 0);

        // Mid-frame reset at (5,3): counts clear before the next edge.
        found = 1'b0;
        for (int c = 0; c < 700 && !found; c++) begin
            @(negedge clock);
            if (px4 == 10'd5 && py4 == 10'd3) found = 1'b1;
        end
        chk("find_x5_y3", int'(found), 1);
        #2 reset = 1'b1;
        #1;
        chk_obs("async_reset", sample4(), mk(0, 0, 0, 0, 1, 1, 1, 0).e);
        chk("async_reset_x_div1", int'(px1), 0);
        @(negedge clock);
        #2 reset = 1'b0;

        while (k < 3) @(negedge clock);
        #1;
        chk("restart_first_tick", int'(pt4), 1);
        while (k < 4) @(negedge clock);
        #1;
        chk("restart_x_after_tick", int'(px4), 1);

        repeat (700) @(negedge clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Upstream timing stage of the VGA display path. It divides the system clock down to a pixel rate and runs the horizontal and vertical scan counters. It generates HSYNC/VSYNC and the video-active qualifier. It drives pixel_x/pixel_y and a once-per-frame tick into the ball, paddle and brick renderers downstream.

Parameters:
CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); legal range 1..16
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_POL, 0, sync active level (0 = active-low)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
pixel_tick  out  1  one-clock strobe per pixel period
pixel_x  out  10  current horizontal count, 0..H_TOTAL-1
pixel_y  out  10  current vertical count, 0..V_TOTAL-1
hsync  out  1  horizontal sync to connector
vsync  out  1  vertical sync to connector
video_on  out  1  high while pixel_x<H_ACTIVE and pixel_y<V_ACTIVE
frame_tick  out  1  one-clock pulse at start of vertical blanking

Behaviour:
- Interface: reset is `reset`, asynchronous, active-high. Clock is `clock`. All state is updated on posedge clock.
- Derived values: H_TOTAL = sum of H_* = 800; V_TOTAL = sum of V_* = 525. Both must be <= 1024, or elaboration errors.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pixel_tick = (div_cnt == CLK_DIV-1), combinational.
  - With CLK_DIV=1, pixel_tick is constantly 1.
- Horizontal counter h advances only on pixel_tick. At H_TOTAL-1 it wraps to 0.
- Vertical counter v advances only on pixel_tick when h wraps. At V_TOTAL-1 it wraps to 0.
- pixel_x = h and pixel_y = v, driven directly from the registers.
- hsync and vsync are registered from next-state counts, so they have zero skew relative to pixel_x/pixel_y.
  - hsync is active when H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC (656..751).
  - vsync is active when V_ACTIVE+V_FRONT <= v < V_ACTIVE+V_FRONT+V_SYNC (490..491).
  - Output level = SYNC_POL when active, ~SYNC_POL otherwise.
- video_on is combinational from h and v.
- frame_tick is registered. It is high for exactly one clock: the first clock in which (pixel_x, pixel_y) = (0, V_ACTIVE). It is never re-asserted while those counts persist for the remaining CLK_DIV-1 clocks.
- Reset values:
  - div_cnt = 0, h = 0, v = 0
  - pixel_tick = (CLK_DIV==1)
  - hsync and vsync = ~SYNC_POL (inactive)
  - video_on = 1
  - frame_tick = 0
- Reset mid-frame: all state returns to the reset values immediately. The first pixel_tick after deassertion occurs CLK_DIV clocks after the first active clock edge.
- Wrap case: h=799, v=524, pixel_tick -> h=0, v=0 on the same edge. vsync stays inactive; video_on rises.
- Latency: each count holds for exactly CLK_DIV clocks. The frame period is H_TOTAL*V_TOTAL*CLK_DIV clocks.

Decomposition:
- Shared package vga_timing_pkg holds:
  - the 640x480@60 defaults: H_ACTIVE/H_FRONT/H_SYNC/H_BACK, V_ACTIVE/V_FRONT/V_SYNC/V_BACK
  - derived H_TOTAL and V_TOTAL
  - COORD_W = 10
  - play-field limits reused by the renderers
- One sub-module, pixel_tick_div: the parameterised divider producing pixel_tick.
- Scan counters, sync decode and frame_tick stay in vga_sync_gen.

Test Plan:
- Reset asserted 3 clocks, then released -> during reset: x=0, y=0, hsync=vsync=1, video_on=1, frame_tick=0. First pixel_tick occurs 4 clocks after release.
- Free-run one line -> pixel_x steps 0..799, each value held 4 clocks.
  - hsync low for exactly 384 clocks, starting when pixel_x becomes 656.
  - video_on falls when pixel_x becomes 640.
- Free-run one frame -> vsync low for 2 lines (6400 clocks) starting at y=490. Frame period is 1,680,000 clocks, measured between successive vsync falling edges.
- frame_tick -> single one-clock pulse per frame, coincident with the first clock of x=0, y=480. Pulse spacing is 1,680,000 clocks.
- Assert reset at x=300, y=200 for 1 clock -> counters reach 0 asynchronously, before the next edge. Timing then restarts exactly as after power-on reset.
- CLK_DIV=1 build -> pixel_tick constantly 1, pixel_x increments every clock, frame period 420,000 clocks.
